// File: rtl/rx_ddr_packer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rx_ddr_packer_if                                              |
// | Purpose  : Word-level valid/ready bus between the receive byte packer    |
// |            and the DDR3 write path.                                      |
// | Signals  : wr_valid - word valid (producer)                              |
// |            wr_ready - word accepted (consumer)                           |
// |            wr_data  - 256-bit packed word, first byte in [7:0]           |
// |            wr_addr  - 25-bit word address                                |
// |            wr_last  - word ends a frame                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface rx_ddr_packer_if;
  logic         wr_valid;
  logic         wr_ready;
  logic [255:0] wr_data;
  logic [24:0]  wr_addr;
  logic         wr_last;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_addr,
    output wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_addr,
    input  wr_last,
    output wr_ready
  );
endinterface
`default_nettype wire

// File: rtl/rx_ddr_packer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rx_ddr_packer                                                 |
// | Purpose  : Packs the voted receive byte stream into 256-bit words, tags  |
// |            the frame-ending word, assigns circular DDR3 word addresses   |
// |            and presents words on a valid/ready bus.                      |
// | Ports    : clk125MHz   - clock                                           |
// |            RST         - synchronous active-high reset                   |
// |            rx_en       - byte strobe, high for the whole frame           |
// |            rx_data     - received byte                                   |
// |            wr          - word bus (master side)                          |
// |            frame_count - frames committed with wr_last=1                 |
// |            word_count  - words accepted by the consumer                  |
// |            drop_count  - words discarded because the holder was busy     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rx_ddr_packer #(
  parameter logic [24:0] BASE_ADDR  = 25'd0,
  parameter logic [24:0] ADDR_LIMIT = 25'h1FFFFFF,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic                   clk125MHz,
  input  logic                   RST,
  input  logic                   rx_en,
  input  logic [7:0]             rx_data,
  rx_ddr_packer_if.master        wr,
  output logic [31:0]            frame_count,
  output logic [31:0]            word_count,
  output logic [31:0]            drop_count
);

  localparam logic [5:0] FULL_CNT = 6'd32;

  // Fill side
  logic [255:0] fill_q,     fill_d;
  logic [5:0]   fill_cnt_q, fill_cnt_d;
  logic         rx_en_d_q,  rx_en_d_d;

  // Holding (output) side
  logic         wr_valid_q, wr_valid_d;
  logic [255:0] wr_data_q,  wr_data_d;
  logic [24:0]  wr_addr_q,  wr_addr_d;
  logic         wr_last_q,  wr_last_d;
  logic [24:0]  addr_ctr_q, addr_ctr_d;

  logic [31:0]  frame_count_q, frame_count_d;
  logic [31:0]  word_count_q,  word_count_d;
  logic [31:0]  drop_count_q,  drop_count_d;

  logic         commit;
  logic         commit_last;
  logic [255:0] commit_data;
  logic         accept;

  always_comb begin
    fill_d      = fill_q;
    fill_cnt_d  = fill_cnt_q;
    rx_en_d_d   = rx_en;
    commit      = 1'b0;
    commit_last = 1'b0;
    commit_data = fill_q;

    if (rx_en) begin
      if (fill_cnt_q == FULL_CNT) begin
        // A full word is only released once another byte proves it is not
        // the frame's last word; that byte opens the next word in lane 0.
        commit         = 1'b1;
        fill_d[7:0]    = rx_data;
        fill_cnt_d     = 6'd1;
      end else begin
        for (int i = 0; i < 32; i++) begin
          if (fill_cnt_q[4:0] == 5'(i)) begin
            fill_d[i*8 +: 8] = rx_data;
          end
        end
        fill_cnt_d = fill_cnt_q + 6'd1;
      end
    end else if (rx_en_d_q && (fill_cnt_q != 6'd0)) begin
      // Frame end: lanes never written in this word are stale, so pad them.
      commit      = 1'b1;
      commit_last = 1'b1;
      for (int i = 0; i < 32; i++) begin
        if (6'(i) >= fill_cnt_q) begin
          commit_data[i*8 +: 8] = PAD_BYTE;
        end
      end
      fill_cnt_d = 6'd0;
    end
  end

  always_comb begin
    accept        = wr_valid_q && wr.wr_ready;
    wr_valid_d    = wr_valid_q && !accept;
    wr_data_d     = wr_data_q;
    wr_addr_d     = wr_addr_q;
    wr_last_d     = wr_last_q;
    addr_ctr_d    = addr_ctr_q;
    frame_count_d = frame_count_q;
    word_count_d  = word_count_q + {31'd0, accept};
    drop_count_d  = drop_count_q;

    if (commit) begin
      // The holder can take a new word when empty or when its current word
      // leaves this very cycle; otherwise the new word is lost.
      if (!wr_valid_q || accept) begin
        wr_valid_d = 1'b1;
        wr_data_d  = commit_data;
        wr_addr_d  = addr_ctr_q;
        wr_last_d  = commit_last;
        addr_ctr_d = (addr_ctr_q == ADDR_LIMIT) ? BASE_ADDR : addr_ctr_q + 25'd1;
        if (commit_last) begin
          frame_count_d = frame_count_q + 32'd1;
        end
      end else begin
        drop_count_d = drop_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk125MHz) begin
    if (RST) begin
      fill_q        <= '0;
      fill_cnt_q    <= 6'd0;
      rx_en_d_q     <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_data_q     <= '0;
      wr_addr_q     <= BASE_ADDR;
      wr_last_q     <= 1'b0;
      addr_ctr_q    <= BASE_ADDR;
      frame_count_q <= 32'd0;
      word_count_q  <= 32'd0;
      drop_count_q  <= 32'd0;
    end else begin
      fill_q        <= fill_d;
      fill_cnt_q    <= fill_cnt_d;
      rx_en_d_q     <= rx_en_d_d;
      wr_valid_q    <= wr_valid_d;
      wr_data_q     <= wr_data_d;
      wr_addr_q     <= wr_addr_d;
      wr_last_q     <= wr_last_d;
      addr_ctr_q    <= addr_ctr_d;
      frame_count_q <= frame_count_d;
      word_count_q  <= word_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign wr.wr_valid   = wr_valid_q;
  assign wr.wr_data    = wr_data_q;
  assign wr.wr_addr    = wr_addr_q;
  assign wr.wr_last    = wr_last_q;
  assign frame_count   = frame_count_q;
  assign word_count    = word_count_q;
  assign drop_count    = drop_count_q;

endmodule
`default_nettype wire
